// File: rtl/genexu_mul_div_pipe.sv
// RISC-V M-extension execution unit with a pipelined multiplier, an iterative radix-2 divider and an in-order response FIFO.
// Credit counting bounds outstanding work to the FIFO depth, so a stalled consumer never loses a result.
module genexu_mul_div_pipe #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int RESP_DEPTH = 4,
  parameter int TAG_W      = 5,
  parameter int TRX_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stream_req_bus_genfifo_req_i,
  output logic             stream_req_bus_genfifo_ack_o,
  input  logic [2:0]       req_exu_opcode_i,
  input  logic [XLEN-1:0]  req_src0_data_i,
  input  logic [XLEN-1:0]  req_src1_data_i,
  input  logic             req_rd0_req_i,
  input  logic [TAG_W-1:0] req_rd0_tag_i,
  input  logic [TRX_W-1:0] req_trx_id_i,
  output logic             stream_resp_bus_genfifo_req_o,
  input  logic             stream_resp_bus_genfifo_ack_i,
  output logic [XLEN-1:0]  resp_rd0_wdata_o,
  output logic             resp_rd0_req_o,
  output logic [TAG_W-1:0] resp_rd0_tag_o,
  output logic [TRX_W-1:0] resp_trx_id_o,
  output logic             resp_alu_CF_o,
  output logic             resp_alu_SF_o,
  output logic             resp_alu_ZF_o,
  output logic             resp_alu_OF_o
);

  localparam int AW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int NW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int MP = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } div_st_t;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Quotient of a zero divisor is forced to all ones; every other case falls out of the magnitudes.
  function automatic logic [XLEN-1:0] div_fixup(input logic [XLEN-1:0] quo, input logic [XLEN-1:0] rem,
                                                input logic is_rem, input logic q_neg, input logic r_neg,
                                                input logic div0);
    if (is_rem)    return cond_neg(rem, r_neg);
    else if (div0) return '1;
    else           return cond_neg(quo, q_neg);
  endfunction

  logic            w_is_div, w_ack, w_acc, w_acc_mul, w_acc_div;
  logic            w_mul_busy, w_mul_push, w_div_push, w_push, w_pop;
  logic [XLEN-1:0] w_mul_res, w_mul_wdata, w_div_wdata, w_push_wdata;
  logic            w_mul_rd0, w_push_rd0;
  logic [TAG_W-1:0] w_mul_tag, w_push_tag;
  logic [TRX_W-1:0] w_mul_trx, w_push_trx;

  div_st_t         r_div_st, w_div_st_nxt;
  logic [NW-1:0]   r_div_cnt;
  logic [CW-1:0]   r_outst, r_fcnt;
  logic [AW-1:0]   r_wr, r_rd;

  assign w_is_div  = req_exu_opcode_i[2];
  assign w_ack     = (r_outst < CW'(RESP_DEPTH)) && (r_div_st == S_IDLE) && (!w_is_div || !w_mul_busy);
  assign w_acc     = stream_req_bus_genfifo_req_i & w_ack;
  assign w_acc_mul = w_acc & ~w_is_div;
  assign w_acc_div = w_acc & w_is_div;
  assign stream_req_bus_genfifo_ack_o = w_ack;

  // ---- multiplier p0: operand extension and full-width product ----
  logic                   w_a_sgn, w_b_sgn;
  logic signed [2*XLEN-1:0] w_a_ext, w_b_ext, w_prod;

  assign w_a_sgn = (req_exu_opcode_i[1:0] == 2'd1) || (req_exu_opcode_i[1:0] == 2'd2);
  assign w_b_sgn = (req_exu_opcode_i[1:0] == 2'd1);
  assign w_a_ext = {{XLEN{w_a_sgn & req_src0_data_i[XLEN-1]}}, req_src0_data_i};
  assign w_b_ext = {{XLEN{w_b_sgn & req_src1_data_i[XLEN-1]}}, req_src1_data_i};
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_mul_res = (req_exu_opcode_i[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // ---- multiplier p1..pN: result and sideband delay line ----
  if (MUL_STAGES == 1) begin : g_mul_comb
    assign w_mul_push  = w_acc_mul;
    assign w_mul_busy  = 1'b0;
    assign w_mul_wdata = w_mul_res;
    assign w_mul_rd0   = req_rd0_req_i;
    assign w_mul_tag   = req_rd0_tag_i;
    assign w_mul_trx   = req_trx_id_i;
  end else begin : g_mul_pipe
    logic [MP-1:0]    r_vld_p;
    logic [XLEN-1:0]  r_res_p [MP];
    logic [MP-1:0]    r_rd0_p;
    logic [TAG_W-1:0] r_tag_p [MP];
    logic [TRX_W-1:0] r_trx_p [MP];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_vld_p <= '0;
      end else begin
        r_vld_p[0] <= w_acc_mul;
        for (int s = 1; s < MP; s++) r_vld_p[s] <= r_vld_p[s-1];
      end
    end

    always_ff @(posedge clk_i) begin
      r_res_p[0] <= w_mul_res;
      r_rd0_p[0] <= req_rd0_req_i;
      r_tag_p[0] <= req_rd0_tag_i;
      r_trx_p[0] <= req_trx_id_i;
      for (int s = 1; s < MP; s++) begin
        r_res_p[s] <= r_res_p[s-1];
        r_rd0_p[s] <= r_rd0_p[s-1];
        r_tag_p[s] <= r_tag_p[s-1];
        r_trx_p[s] <= r_trx_p[s-1];
      end
    end

    assign w_mul_push  = r_vld_p[MP-1];
    assign w_mul_busy  = |r_vld_p;
    assign w_mul_wdata = r_res_p[MP-1];
    assign w_mul_rd0   = r_rd0_p[MP-1];
    assign w_mul_tag   = r_tag_p[MP-1];
    assign w_mul_trx   = r_trx_p[MP-1];
  end

  // ---- divider: magnitudes and sign flags are latched on the accept edge ----
  logic            w_div_sgn, w_a_neg, w_b_neg, w_fits;
  logic [XLEN-1:0] w_a_abs, w_b_abs, w_diff;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] r_dvs, r_quo, r_rem;
  logic            r_q_neg, r_r_neg, r_div0, r_is_rem, r_div_rd0;
  logic [TAG_W-1:0] r_div_tag;
  logic [TRX_W-1:0] r_div_trx;

  assign w_div_sgn = ~req_exu_opcode_i[0];
  assign w_a_neg   = w_div_sgn & req_src0_data_i[XLEN-1];
  assign w_b_neg   = w_div_sgn & req_src1_data_i[XLEN-1];
  assign w_a_abs   = cond_neg(req_src0_data_i, w_a_neg);
  assign w_b_abs   = cond_neg(req_src1_data_i, w_b_neg);

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_fits  = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[XLEN-1:0] - r_dvs;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_div_st <= S_IDLE;
    else       r_div_st <= w_div_st_nxt;
  end

  always_comb begin
    w_div_st_nxt = r_div_st;
    w_div_push   = 1'b0;
    case (r_div_st)
      S_IDLE: if (w_acc_div) w_div_st_nxt = S_ITER;
      S_ITER: if (r_div_cnt == '0) w_div_st_nxt = S_DONE;
      S_DONE: begin
        w_div_push   = 1'b1;
        w_div_st_nxt = S_IDLE;
      end
      default: w_div_st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                  r_div_cnt <= '0;
    else if (w_acc_div)         r_div_cnt <= NW'(XLEN - 1);
    else if (r_div_st == S_ITER) r_div_cnt <= r_div_cnt - 1'b1;
  end

  // ---- divider iteration: restoring shift-subtract, quotient shifts in at the LSB ----
  always_ff @(posedge clk_i) begin
    if (w_acc_div) begin
      r_dvs     <= w_b_abs;
      r_quo     <= w_a_abs;
      r_rem     <= '0;
      r_q_neg   <= w_a_neg ^ w_b_neg;
      r_r_neg   <= w_a_neg;
      r_div0    <= (req_src1_data_i == '0);
      r_is_rem  <= req_exu_opcode_i[1];
      r_div_rd0 <= req_rd0_req_i;
      r_div_tag <= req_rd0_tag_i;
      r_div_trx <= req_trx_id_i;
    end else if (r_div_st == S_ITER) begin
      r_rem <= w_fits ? w_diff : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_fits};
    end
  end

  assign w_div_wdata = div_fixup(r_quo, r_rem, r_is_rem, r_q_neg, r_r_neg, r_div0);

  // ---- response FIFO: the two producers never push in the same cycle ----
  logic [XLEN-1:0]  r_f_wdata [RESP_DEPTH];
  logic             r_f_rd0   [RESP_DEPTH];
  logic [TAG_W-1:0] r_f_tag   [RESP_DEPTH];
  logic [TRX_W-1:0] r_f_trx   [RESP_DEPTH];

  assign w_push       = w_mul_push | w_div_push;
  assign w_push_wdata = w_div_push ? w_div_wdata : w_mul_wdata;
  assign w_push_rd0   = w_div_push ? r_div_rd0   : w_mul_rd0;
  assign w_push_tag   = w_div_push ? r_div_tag   : w_mul_tag;
  assign w_push_trx   = w_div_push ? r_div_trx   : w_mul_trx;
  assign w_pop        = stream_resp_bus_genfifo_req_o & stream_resp_bus_genfifo_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_fcnt  <= '0;
      r_outst <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_fcnt  <= r_fcnt + CW'(w_push) - CW'(w_pop);
      r_outst <= r_outst + CW'(w_acc) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_f_wdata[r_wr] <= w_push_wdata;
      r_f_rd0[r_wr]   <= w_push_rd0;
      r_f_tag[r_wr]   <= w_push_tag;
      r_f_trx[r_wr]   <= w_push_trx;
    end
  end

  assign stream_resp_bus_genfifo_req_o = (r_fcnt != '0);
  assign resp_rd0_wdata_o = r_f_wdata[r_rd];
  assign resp_rd0_req_o   = r_f_rd0[r_rd];
  assign resp_rd0_tag_o   = r_f_tag[r_rd];
  assign resp_trx_id_o    = r_f_trx[r_rd];
  assign resp_alu_CF_o    = 1'b0;
  assign resp_alu_SF_o    = 1'b0;
  assign resp_alu_ZF_o    = 1'b0;
  assign resp_alu_OF_o    = 1'b0;

  a_fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && (r_fcnt == CW'(RESP_DEPTH))));
  a_single_producer: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_mul_push && w_div_push));

endmodule

// File: tb/tb_genexu_mul_div_pipe.sv
// Scoreboard bench for genexu_mul_div_pipe: the driver queues hand-computed responses, a negedge monitor pops and compares.
module tb_genexu_mul_div_pipe;
  localparam int XLEN = 32, MS = 2, RD = 4, TAG_W = 5, TRX_W = 4;

  logic             clk = 1'b0, rst;
  logic             req, ack_o, resp_req, resp_ack;
  logic [2:0]       op;
  logic [XLEN-1:0]  src0, src1, wdata;
  logic             rd0_in, rd0_out;
  logic [TAG_W-1:0] tag_in, tag_out;
  logic [TRX_W-1:0] trx_in, trx_out;
  logic             cf, sf, zf, of;

  genexu_mul_div_pipe #(.XLEN(XLEN), .MUL_STAGES(MS), .RESP_DEPTH(RD), .TAG_W(TAG_W), .TRX_W(TRX_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .stream_req_bus_genfifo_req_i(req), .stream_req_bus_genfifo_ack_o(ack_o),
    .req_exu_opcode_i(op), .req_src0_data_i(src0), .req_src1_data_i(src1),
    .req_rd0_req_i(rd0_in), .req_rd0_tag_i(tag_in), .req_trx_id_i(trx_in),
    .stream_resp_bus_genfifo_req_o(resp_req), .stream_resp_bus_genfifo_ack_i(resp_ack),
    .resp_rd0_wdata_o(wdata), .resp_rd0_req_o(rd0_out), .resp_rd0_tag_o(tag_out), .resp_trx_id_o(trx_out),
    .resp_alu_CF_o(cf), .resp_alu_SF_o(sf), .resp_alu_ZF_o(zf), .resp_alu_OF_o(of));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] v;
    bit          chk_lat;
    int          vis;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [63:0] pack(input logic [XLEN-1:0] d, input logic r, input logic [TAG_W-1:0] t,
                                       input logic [TRX_W-1:0] x);
    return 64'({d, r, t, x, 4'b0000});
  endfunction

  // Monitor: a pop happens at the next posedge whenever valid and ack are both high here.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_req && resp_ack) begin
      check("resp_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("resp", pack(wdata, rd0_out, tag_out, trx_out) | 64'({cf, sf, zf, of}), e.v);
        if (e.chk_lat) check("resp_cycle", 64'(cyc), 64'(e.vis));
      end
    end
  end

  task automatic drive(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TRX_W-1:0] x, input logic [TAG_W-1:0] t, input logic r);
    op = o; src0 = a; src1 = b; trx_in = x; tag_in = t; rd0_in = r; req = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1 req = 1'b0;
  endtask

  task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TRX_W-1:0] x, input logic [TAG_W-1:0] t, input logic r,
                       input logic [XLEN-1:0] exp, input bit push, input bit lat, input bit stall,
                       output int acc);
    int   waited = 0;
    bit   first = 1'b1;
    bit   got = 1'b0;
    exp_t e;
    @(posedge clk); #1 drive(o, a, b, x, t, r);
    while (!got && waited <= 200) begin
      @(negedge clk);
      if (first && stall) check("stall", 64'(ack_o), 64'd0);
      first = 1'b0;
      if (ack_o) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      check("ack_wait_cycles", 64'(waited), 64'd200);
      req = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      if (push) begin
        e.v = pack(exp, r, t, x);
        e.chk_lat = lat;
        e.vis = cyc + (o[2] ? XLEN + 2 : MS);
        sb.push_back(e);
      end
    end
  endtask

  task automatic t1(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                    input logic [TRX_W-1:0] x, input logic [XLEN-1:0] exp);
    int acc;
    issue(o, a, b, x, TAG_W'(x) + 5'd3, x[0], exp, 1'b1, 1'b1, 1'b0, acc);
    idle();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   a_d, a_m, a_x;
    exp_t e5;
    rst = 1'b1; req = 1'b0; resp_ack = 1'b1;
    op = '0; src0 = '0; src1 = '0; trx_in = '0; tag_in = '0; rd0_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_resp_req", 64'(resp_req), 64'd0);
    check("reset_ack", 64'(ack_o), 64'd1);

    // Multiplier variants
    t1(MUL,    32'd7,        32'hFFFFFFFD, 4'd5, 32'hFFFFFFEB);
    t1(MULH,   32'h80000000, 32'h80000000, 4'd6, 32'h40000000);
    t1(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7, 32'hFFFFFFFE);
    t1(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd8, 32'hFFFFFFFF);
    t1(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9, 32'h00000000);
    wait_drain();

    // Credit exhaustion with a stalled consumer
    @(posedge clk); #1 resp_ack = 1'b0;
    issue(MUL, 32'd3,        32'd4,  4'd1, 5'd11, 1'b1, 32'd12,        1'b1, 1'b0, 1'b0, a_x);
    issue(MUL, 32'hFFFFFFFF, 32'd2,  4'd2, 5'd12, 1'b0, 32'hFFFFFFFE,  1'b1, 1'b0, 1'b0, a_x);
    issue(MUL, 32'd5,        32'd5,  4'd3, 5'd13, 1'b1, 32'd25,        1'b1, 1'b0, 1'b0, a_x);
    issue(MUL, 32'h12345678, 32'h10, 4'd4, 5'd14, 1'b0, 32'h23456780,  1'b1, 1'b0, 1'b0, a_x);
    @(posedge clk); #1 drive(MUL, 32'd100, 32'hFFFFFFFF, 4'd5, 5'd15, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check("credit_full", 64'(ack_o), 64'd0);
    end
    @(posedge clk); #1 resp_ack = 1'b1;
    @(negedge clk);
    check("credit_pop_same_cycle", 64'(ack_o), 64'd0);
    @(negedge clk);
    check("credit_return", 64'(ack_o), 64'd1);
    e5.v = pack(32'hFFFFFF9C, 1'b1, 5'd15, 4'd5);
    e5.chk_lat = 1'b0;
    e5.vis = 0;
    sb.push_back(e5);
    idle();
    wait_drain();

    // Divider results and special cases
    t1(DIV,  32'hFFFFFFF9, 32'd2,        4'd1,  32'hFFFFFFFD);
    t1(REM,  32'hFFFFFFF9, 32'd2,        4'd2,  32'hFFFFFFFF);
    t1(DIVU, 32'hFFFFFFFF, 32'd16,       4'd3,  32'h0FFFFFFF);
    t1(DIV,  32'd123,      32'd0,        4'd4,  32'hFFFFFFFF);
    t1(DIV,  32'hFFFFFFFB, 32'd0,        4'd5,  32'hFFFFFFFF);
    t1(REMU, 32'd5,        32'd0,        4'd6,  32'd5);
    t1(REM,  32'hFFFFFFFB, 32'd0,        4'd7,  32'hFFFFFFFB);
    t1(DIV,  32'h80000000, 32'hFFFFFFFF, 4'd8,  32'h80000000);
    t1(REM,  32'h80000000, 32'hFFFFFFFF, 4'd9,  32'd0);
    t1(DIVU, 32'd100,      32'd7,        4'd10, 32'd14);
    t1(REMU, 32'd100,      32'd7,        4'd11, 32'd2);
    wait_drain();

    // Ordering between the two units
    issue(MUL,  32'd6,   32'd7, 4'd12, 5'd1, 1'b1, 32'd42, 1'b1, 1'b1, 1'b0, a_x);
    issue(DIVU, 32'd100, 32'd7, 4'd13, 5'd2, 1'b0, 32'd14, 1'b1, 1'b1, 1'b1, a_d);
    issue(MUL,  32'd9,   32'd9, 4'd14, 5'd3, 1'b1, 32'd81, 1'b1, 1'b1, 1'b1, a_m);
    idle();
    check("div_after_mul_cycle", 64'(a_d), 64'(a_x + 2));
    check("mul_after_div_cycle", 64'(a_m), 64'(a_d + XLEN + 2));
    wait_drain();

    // Reset with a divide in flight and two results queued
    @(posedge clk); #1 resp_ack = 1'b0;
    issue(MUL, 32'd2, 32'd3, 4'd1, 5'd4, 1'b1, 32'd6, 1'b0, 1'b0, 1'b0, a_x);
    issue(MUL, 32'd4, 32'd5, 4'd2, 5'd5, 1'b1, 32'd20, 1'b0, 1'b0, 1'b0, a_x);
    issue(DIV, 32'd50, 32'd5, 4'd3, 5'd6, 1'b1, 32'd10, 1'b0, 1'b0, 1'b0, a_x);
    idle();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_reset_resp_req", 64'(resp_req), 64'd1);
    check("pre_reset_ack_busy", 64'(ack_o), 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_reset_resp_req", 64'(resp_req), 64'd0);
    check("post_reset_ack", 64'(ack_o), 64'd1);
    resp_ack = 1'b1;
    repeat (50) @(negedge clk);
    t1(MUL, 32'd11, 32'd13, 4'd15, 32'd143);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
